wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Slot-driven Wishbone arbiter that shares the single system Wishbone bus (RAM bridge, register file, keyboard) among up to `NUM_CTL` controllers (0 = SPI1, 1 = video, 2 = spare/DMA). It issues at most one transaction per timing-generator slot, tracks the outstanding transaction until ACK, routes ACK and read data back to the owner, and recovers from a missing ACK with a timeout. It replaces the ad-hoc strobe/cycle ORing in `main`, and adds optional donation of idle slots to other requesters.

## Interface

- `NUM_CTL`, 3, number of controllers (2..8)
- `TIMEOUT`, 15, cycles to wait for `wb_ack_i` after issue before forced completion (1..255)
- `DONATE`, 1, 1 = give an unused slot to another requester in round-robin order; 0 = unused slot is idle

Ports:

- `wb_clock_i` in 1: 64 MHz system clock
- `wb_reset_ni` in 1: synchronous, active-low reset
- `slot_grant_i` in NUM_CTL: one-hot slot owner from `timing`
- `slot_strobe_i` in 1: single-cycle slot pulse from `timing`
- `ctl_addr_i` in NUM_CTL*WB_ADDR_WIDTH: packed controller addresses, ctl k at [k*W +: W]
- `ctl_data_i` in NUM_CTL*DATA_WIDTH: packed write data
- `ctl_we_i`, `ctl_cycle_i`, `ctl_strobe_i` in NUM_CTL each: per-controller WB control
- `ctl_stall_o` out NUM_CTL: per-controller stall
- `ctl_ack_o` out NUM_CTL: per-controller ack
- `ctl_data_o` out DATA_WIDTH: shared read data (valid with `ctl_ack_o`)
- `wb_addr_o` out WB_ADDR_WIDTH, `wb_data_o` out DATA_WIDTH, `wb_we_o`, `wb_cycle_o`, `wb_strobe_o` out 1: to peripherals
- `wb_stall_i`, `wb_ack_i` in 1, `wb_data_i` in DATA_WIDTH: from peripherals (ORed stall/ack, muxed data)
- `busy_o` out 1: transaction outstanding
- `owner_o` out clog2(NUM_CTL): current/last owner index
- `timeout_o` out 1: sticky, set on forced completion
- `timeout_clear_i` in 1: clears `timeout_o`

## Operation

- States: IDLE, WAIT_ACK.
- Candidate in IDLE: if `slot_strobe_i` and granted ctl g has `ctl_cycle_i[g] & ctl_strobe_i[g]` -> candidate g. Else if `DONATE` and any ctl requests -> first requester scanning from `rr_ptr` upward, modulo NUM_CTL. Else none.
- Issue (IDLE, candidate c, `!wb_stall_i`): `wb_strobe_o`=1 this cycle; `wb_cycle_o`, addr/data/we from c; `ctl_stall_o[c]`=0; register `owner`=c; load timer=0; -> WAIT_ACK. Donated issue sets `rr_ptr`=(c+1) mod NUM_CTL; slot-owner issue leaves `rr_ptr` unchanged.
- `wb_stall_i` high at slot: slot lost, no issue, state unchanged.
- `ctl_stall_o[k]`=1 except for the issuing ctl in its issue cycle.
- WAIT_ACK: `wb_cycle_o`=`ctl_cycle_i[owner]`; addr/data/we held from owner; `wb_strobe_o`=0; all stalls=1; timer increments.
  - `wb_ack_i` -> `ctl_ack_o[owner]`=1, `ctl_data_o`=`wb_data_i`, same cycle; -> IDLE.
  - Timer == TIMEOUT with no ack -> `ctl_ack_o[owner]`=1, `ctl_data_o`=8'hFF, `timeout_o`<=1; -> IDLE.
  - `ctl_cycle_i[owner]` low (abort) -> IDLE without ack.
- `wb_ack_i` in IDLE (late/stray): dropped, no `ctl_ack_o`.
- Multiple `slot_grant_i` bits: lowest index wins; simulation assertion fails.
- `timeout_clear_i` and timeout set in same cycle: set wins.
- `ctl_data_o`=`wb_data_i` when not forcing timeout data.

## Timing

- Reset (sampled on `wb_clock_i` with `wb_reset_ni`=0): state IDLE, `owner`=0, `rr_ptr`=0, timer=0, `timeout_o`=0, `busy_o`=0; combinational outputs are then `wb_strobe_o`=0, `wb_cycle_o`=OR of candidate cycle (0 with no slot), all `ctl_ack_o`=0, all `ctl_stall_o`=1 except an issuing ctl. Reset mid-transaction abandons it; a subsequent ack is dropped.
- Issue latency: 0 cycles from `slot_strobe_i` (combinational strobe).
- Ack latency to controller: 0 cycles from `wb_ack_i`.
- Ack in the cycle after issue is legal; the earliest next issue is the cycle after the ack.
- Forced completion fires at the TIMEOUT-th cycle of WAIT_ACK (issue cycle = 0).
- `busy_o`=1 exactly while in WAIT_ACK (registered).

## Test plan

- Ctl0 granted, reads addr 0x1234; RAM acks 2 cycles later with 0x5A -> single `wb_strobe_o` pulse, `ctl_ack_o`=3'b001 with `ctl_data_o`=0x5A, `busy_o` high for 2 cycles.
- Ctl1 slot while ctl1 idle, ctl2 requesting, DONATE=1 -> ctl2 issues, `rr_ptr`=0; with DONATE=0 -> no strobe.
- `wb_stall_i`=1 on ctl0 slot -> no strobe, ctl0 stall stays 1; next ctl0 slot with stall=0 -> issues.
- No ack, TIMEOUT=15 -> `ctl_ack_o[owner]` on WAIT_ACK cycle 15, data 0xFF, `timeout_o`=1 until `timeout_clear_i`.
- Owner drops `ctl_cycle_i` in WAIT_ACK, then ack arrives -> IDLE, no `ctl_ack_o`.
- `wb_reset_ni` low during WAIT_ACK -> `busy_o`=0, `timeout_o`=0 next cycle; the late ack is ignored.

Source files
------------

// File: rtl/wb_arbiter.sv
// Slot-driven Wishbone arbiter: one transaction per timing slot, optional donation of
// idle slots in round-robin order, ack routing back to the owner and ack timeout recovery.
module wb_arbiter #(
   parameter int NUM_CTL       = 3,
   parameter int TIMEOUT       = 15,
   parameter bit DONATE        = 1'b1,
   parameter int WB_ADDR_WIDTH = 16,
   parameter int DATA_WIDTH    = 8,
   localparam int OW           = $clog2(NUM_CTL)
) (
   input  logic                             wb_clock_i,
   input  logic                             wb_reset_ni,
   input  logic [NUM_CTL-1:0]               slot_grant_i,
   input  logic                             slot_strobe_i,
   input  logic [NUM_CTL*WB_ADDR_WIDTH-1:0] ctl_addr_i,
   input  logic [NUM_CTL*DATA_WIDTH-1:0]    ctl_data_i,
   input  logic [NUM_CTL-1:0]               ctl_we_i,
   input  logic [NUM_CTL-1:0]               ctl_cycle_i,
   input  logic [NUM_CTL-1:0]               ctl_strobe_i,
   output logic [NUM_CTL-1:0]               ctl_stall_o,
   output logic [NUM_CTL-1:0]               ctl_ack_o,
   output logic [DATA_WIDTH-1:0]            ctl_data_o,
   output logic [WB_ADDR_WIDTH-1:0]         wb_addr_o,
   output logic [DATA_WIDTH-1:0]            wb_data_o,
   output logic                             wb_we_o,
   output logic                             wb_cycle_o,
   output logic                             wb_strobe_o,
   input  logic                             wb_stall_i,
   input  logic                             wb_ack_i,
   input  logic [DATA_WIDTH-1:0]            wb_data_i,
   output logic                             busy_o,
   output logic [OW-1:0]                    owner_o,
   output logic                             timeout_o,
   input  logic                             timeout_clear_i
);

   localparam logic [0:0] IDLE     = 1'b0;
   localparam logic [0:0] WAIT_ACK = 1'b1;

   logic [0:0]         state;
   logic [OW-1:0]      owner;
   logic [OW-1:0]      rr_ptr;
   logic [7:0]         timer;
   logic [NUM_CTL-1:0] req;
   logic [OW-1:0]      grant_idx;
   logic               grant_any;
   logic [OW-1:0]      don_idx;
   logic               don_any;
   logic [OW-1:0]      scan_idx;
   logic [OW-1:0]      cand;
   logic               cand_any;
   logic               donated;
   logic               issue;
   logic [OW-1:0]      sel;
   logic               in_wait;
   logic               owner_cyc;
   logic               abort;
   logic               acked;
   logic               fire;

   assign req     = ctl_cycle_i & ctl_strobe_i;
   assign in_wait = (state == WAIT_ACK);

   // Lowest set grant bit wins when the timing generator misbehaves.
   always_comb begin
      grant_idx = '0;
      grant_any = 1'b0;
      for (int k = NUM_CTL - 1; k >= 0; k--) begin
         if (slot_grant_i[k]) begin
            grant_idx = OW'(k);
            grant_any = 1'b1;
         end
      end
   end

   always_comb begin
      don_idx  = '0;
      don_any  = 1'b0;
      scan_idx = '0;
      for (int i = 0; i < NUM_CTL; i++) begin
         scan_idx = OW'((int'(rr_ptr) + i) % NUM_CTL);
         if (!don_any && req[scan_idx]) begin
            don_any = 1'b1;
            don_idx = scan_idx;
         end
      end
   end

   always_comb begin
      cand     = '0;
      cand_any = 1'b0;
      donated  = 1'b0;
      if (!in_wait && slot_strobe_i) begin
         if (grant_any && req[grant_idx]) begin
            cand     = grant_idx;
            cand_any = 1'b1;
         end else if (DONATE && don_any) begin
            cand     = don_idx;
            cand_any = 1'b1;
            donated  = 1'b1;
         end
      end
   end

   assign issue     = cand_any && !wb_stall_i;
   assign sel       = cand_any ? cand : owner;
   assign owner_cyc = ctl_cycle_i[owner];
   assign abort     = in_wait && !owner_cyc;
   assign acked     = in_wait && owner_cyc && wb_ack_i;
   assign fire      = in_wait && owner_cyc && !wb_ack_i && (timer == 8'(TIMEOUT - 1));

   always_comb begin
      wb_addr_o = '0;
      wb_data_o = '0;
      wb_we_o   = 1'b0;
      for (int k = 0; k < NUM_CTL; k++) begin
         if (OW'(k) == sel) begin
            wb_addr_o = ctl_addr_i[k*WB_ADDR_WIDTH +: WB_ADDR_WIDTH];
            wb_data_o = ctl_data_i[k*DATA_WIDTH +: DATA_WIDTH];
            wb_we_o   = ctl_we_i[k];
         end
      end
   end

   always_comb begin
      ctl_stall_o = '1;
      ctl_ack_o   = '0;
      for (int k = 0; k < NUM_CTL; k++) begin
         if (issue && OW'(k) == cand) ctl_stall_o[k] = 1'b0;
         if ((acked || fire) && OW'(k) == owner) ctl_ack_o[k] = 1'b1;
      end
   end

   assign ctl_data_o  = fire ? '1 : wb_data_i;
   assign wb_strobe_o = issue;
   assign wb_cycle_o  = in_wait ? owner_cyc : cand_any;
   assign busy_o      = in_wait;
   assign owner_o     = owner;

   always_ff @(posedge wb_clock_i) begin
      if (!wb_reset_ni) begin
         state     <= IDLE;
         owner     <= '0;
         rr_ptr    <= '0;
         timer     <= '0;
         timeout_o <= 1'b0;
      end else begin
         if (fire) timeout_o <= 1'b1;
         else if (timeout_clear_i) timeout_o <= 1'b0;

         if (!in_wait) begin
            if (issue) begin
               state <= WAIT_ACK;
               owner <= cand;
               timer <= '0;
               if (donated) rr_ptr <= (cand == OW'(NUM_CTL - 1)) ? '0 : cand + 1'b1;
            end
         end else begin
            timer <= timer + 8'd1;
            if (abort || acked || fire) state <= IDLE;
         end
      end
   end

   always_ff @(posedge wb_clock_i) begin
      if (wb_reset_ni) assert ($onehot0(slot_grant_i));
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios followed by random traffic, every cycle
// compared against a transaction-level reference model.
module tb_wb_arbiter;

   localparam int NUM = 3;
   localparam int TMO = 15;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [2:0]  grant;
   logic        slot;
   logic [15:0] addr_a [3];
   logic [7:0]  wdat_a [3];
   logic [2:0]  we, cyc, stb;
   logic        stall, ack, tclr;
   logic [7:0]  rdat;
   logic [47:0] ctl_addr;
   logic [23:0] ctl_wdat;

   assign ctl_addr = {addr_a[2], addr_a[1], addr_a[0]};
   assign ctl_wdat = {wdat_a[2], wdat_a[1], wdat_a[0]};

   logic [2:0]  c_stall, c_ack, z_stall, z_ack;
   logic [7:0]  c_data, w_data, z_cdata, z_wdata;
   logic [15:0] w_addr, z_addr;
   logic        w_we, w_cyc, w_stb, busy, tmo;
   logic        z_we, z_cyc, z_stb, z_busy, z_tmo;
   logic [1:0]  owner, z_owner;

   wb_arbiter #(.NUM_CTL(NUM), .TIMEOUT(TMO), .DONATE(1'b1)) dut (
      .wb_clock_i(clk), .wb_reset_ni(rst_n), .slot_grant_i(grant), .slot_strobe_i(slot),
      .ctl_addr_i(ctl_addr), .ctl_data_i(ctl_wdat), .ctl_we_i(we), .ctl_cycle_i(cyc),
      .ctl_strobe_i(stb), .ctl_stall_o(c_stall), .ctl_ack_o(c_ack), .ctl_data_o(c_data),
      .wb_addr_o(w_addr), .wb_data_o(w_data), .wb_we_o(w_we), .wb_cycle_o(w_cyc),
      .wb_strobe_o(w_stb), .wb_stall_i(stall), .wb_ack_i(ack), .wb_data_i(rdat),
      .busy_o(busy), .owner_o(owner), .timeout_o(tmo), .timeout_clear_i(tclr));

   wb_arbiter #(.NUM_CTL(NUM), .TIMEOUT(TMO), .DONATE(1'b0)) dut0 (
      .wb_clock_i(clk), .wb_reset_ni(rst_n), .slot_grant_i(grant), .slot_strobe_i(slot),
      .ctl_addr_i(ctl_addr), .ctl_data_i(ctl_wdat), .ctl_we_i(we), .ctl_cycle_i(cyc),
      .ctl_strobe_i(stb), .ctl_stall_o(z_stall), .ctl_ack_o(z_ack), .ctl_data_o(z_cdata),
      .wb_addr_o(z_addr), .wb_data_o(z_wdata), .wb_we_o(z_we), .wb_cycle_o(z_cyc),
      .wb_strobe_o(z_stb), .wb_stall_i(stall), .wb_ack_i(ack), .wb_data_i(rdat),
      .busy_o(z_busy), .owner_o(z_owner), .timeout_o(z_tmo), .timeout_clear_i(tclr));

   int total = 0;
   int bad   = 0;

   // Reference model of the DONATE=1 arbiter: transaction in flight, its owner, its age.
   bit m_busy, m_tmo;
   int m_owner, m_rr, m_age;
   bit n_issue, n_don, n_end, n_fire;
   int n_cand;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_check();
      int g, cand, sel;
      bit don, e_cyc;
      logic [2:0] e_stall, e_ack;
      logic [7:0] e_data;
      g = -1;
      for (int k = NUM - 1; k >= 0; k--) if (grant[k]) g = k;
      cand = -1;
      don  = 1'b0;
      if (!m_busy && slot) begin
         if (g >= 0 && cyc[g[1:0]] && stb[g[1:0]]) cand = g;
         else begin
            for (int i = 0; i < NUM; i++) begin
               int k;
               k = (m_rr + i) % NUM;
               if (cand < 0 && cyc[k[1:0]] && stb[k[1:0]]) begin
                  cand = k;
                  don  = 1'b1;
               end
            end
         end
      end
      n_issue = (cand >= 0) && !stall;
      n_cand  = cand;
      n_don   = don;
      n_end   = 1'b0;
      n_fire  = 1'b0;
      e_ack   = 3'b000;
      if (m_busy) begin
         if (!cyc[m_owner[1:0]]) n_end = 1'b1;
         else if (ack) begin
            n_end = 1'b1;
            e_ack[m_owner[1:0]] = 1'b1;
         end else if (m_age == TMO) begin
            n_end  = 1'b1;
            n_fire = 1'b1;
            e_ack[m_owner[1:0]] = 1'b1;
         end
      end
      e_data  = n_fire ? 8'hFF : rdat;
      e_stall = 3'b111;
      if (n_issue) e_stall[cand[1:0]] = 1'b0;
      e_cyc = m_busy ? cyc[m_owner[1:0]] : (cand >= 0);
      sel   = m_busy ? m_owner : cand;

      chk("strobe", 32'(w_stb), 32'(n_issue));
      chk("stall", 32'(c_stall), 32'(e_stall));
      chk("ack", 32'(c_ack), 32'(e_ack));
      chk("cycle", 32'(w_cyc), 32'(e_cyc));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("owner", 32'(owner), 32'(m_owner));
      chk("timeout", 32'(tmo), 32'(m_tmo));
      if (e_ack != 3'b000) chk("rdata", 32'(c_data), 32'(e_data));
      if (n_issue || m_busy) begin
         chk("addr", 32'(w_addr), 32'(addr_a[sel[1:0]]));
         chk("wdata", 32'(w_data), 32'(wdat_a[sel[1:0]]));
         chk("we", 32'(w_we), 32'(we[sel[1:0]]));
      end
   endtask

   task automatic model_advance();
      if (!rst_n) begin
         m_busy = 1'b0; m_owner = 0; m_rr = 0; m_age = 0; m_tmo = 1'b0;
      end else begin
         if (n_fire) m_tmo = 1'b1;
         else if (tclr) m_tmo = 1'b0;
         if (n_issue) begin
            m_busy  = 1'b1;
            m_owner = n_cand;
            m_age   = 1;
            if (n_don) m_rr = (n_cand + 1) % NUM;
         end else if (m_busy) begin
            if (n_end) m_busy = 1'b0;
            else m_age++;
         end
      end
   endtask

   task automatic step();
      @(negedge clk);
      model_check();
      @(posedge clk);
      model_advance();
      #1;
   endtask

   task automatic set_req(input int k, input logic [15:0] a, input logic w, input logic [7:0] d);
      cyc[k[1:0]]    = 1'b1;
      stb[k[1:0]]    = 1'b1;
      we[k[1:0]]     = w;
      addr_a[k[1:0]] = a;
      wdat_a[k[1:0]] = d;
   endtask

   initial begin
      rst_n = 1'b0; grant = '0; slot = 1'b0; we = '0; cyc = '0; stb = '0;
      stall = 1'b0; ack = 1'b0; tclr = 1'b0; rdat = '0;
      for (int k = 0; k < NUM; k++) begin
         addr_a[k] = '0;
         wdat_a[k] = '0;
      end
      @(posedge clk);
      #1;
      m_busy = 1'b0; m_owner = 0; m_rr = 0; m_age = 0; m_tmo = 1'b0;
      step();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_stall", 32'(c_stall), 32'h7);
      rst_n = 1'b1;
      step();

      // Ctl0 read of 0x1234 acked two cycles later
      set_req(0, 16'h1234, 1'b0, 8'h00);
      grant = 3'b001; slot = 1'b1;
      #1;
      chk("t1_strobe", 32'(w_stb), 32'd1);
      chk("t1_addr", 32'(w_addr), 32'h1234);
      step();
      slot = 1'b0; grant = '0; stb[0] = 1'b0;
      step();
      ack = 1'b1; rdat = 8'h5A;
      #1;
      chk("t1_ack", 32'(c_ack), 32'h1);
      chk("t1_data", 32'(c_data), 32'h5A);
      step();
      ack = 1'b0; cyc[0] = 1'b0;
      chk("t1_idle", 32'(busy), 32'd0);
      step();

      // Ctl1 slot unused, ctl2 requesting: donated only when DONATE=1
      set_req(2, 16'hBEEF, 1'b1, 8'h11);
      grant = 3'b010; slot = 1'b1;
      #1;
      chk("t2_strobe", 32'(w_stb), 32'd1);
      chk("t2_stall", 32'(c_stall), 32'h3);
      chk("t2_nodonate", 32'(z_stb), 32'd0);
      chk("t2_nodonate_stall", 32'(z_stall), 32'h7);
      step();
      slot = 1'b0; grant = '0; stb[2] = 1'b0;
      chk("t2_owner", 32'(owner), 32'd2);
      ack = 1'b1; rdat = 8'h33;
      step();
      ack = 1'b0; cyc[2] = 1'b0;
      step();

      // Stalled slot is lost; next slot issues
      set_req(0, 16'h0400, 1'b1, 8'hC3);
      grant = 3'b001; slot = 1'b1; stall = 1'b1;
      #1;
      chk("t3_strobe", 32'(w_stb), 32'd0);
      chk("t3_stall", 32'(c_stall), 32'h7);
      step();
      slot = 1'b0; stall = 1'b0;
      step();
      slot = 1'b1;
      #1;
      chk("t3_issue", 32'(w_stb), 32'd1);
      chk("t3_wdata", 32'(w_data), 32'hC3);
      step();
      slot = 1'b0; grant = '0; stb[0] = 1'b0;

      // No ack: forced completion in WAIT_ACK cycle 15
      repeat (14) step();
      chk("t4_ack", 32'(c_ack), 32'h1);
      chk("t4_data", 32'(c_data), 32'hFF);
      step();
      chk("t4_sticky", 32'(tmo), 32'd1);
      chk("t4_idle", 32'(busy), 32'd0);

      // Reset mid-transaction, late ack dropped
      stb[0] = 1'b1; grant = 3'b001; slot = 1'b1;
      step();
      slot = 1'b0; grant = '0; stb[0] = 1'b0;
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("t6_busy", 32'(busy), 32'd0);
      chk("t6_tmo", 32'(tmo), 32'd0);
      ack = 1'b1; rdat = 8'h77;
      #1;
      chk("t6_late_ack", 32'(c_ack), 32'h0);
      step();
      ack = 1'b0;

      // Owner aborts, then ack arrives
      stb[0] = 1'b1; grant = 3'b001; slot = 1'b1;
      step();
      slot = 1'b0; grant = '0; stb[0] = 1'b0;
      step();
      cyc[0] = 1'b0;
      step();
      ack = 1'b1;
      #1;
      chk("t5_noack", 32'(c_ack), 32'h0);
      step();
      ack = 1'b0;

      // Timeout set wins over a simultaneous clear
      set_req(1, 16'h2222, 1'b0, 8'h00);
      grant = 3'b010; slot = 1'b1;
      step();
      slot = 1'b0; grant = '0; stb[1] = 1'b0; tclr = 1'b1;
      repeat (15) step();
      chk("t7_set_wins", 32'(tmo), 32'd1);
      step();
      chk("t7_cleared", 32'(tmo), 32'd0);
      tclr = 1'b0; cyc = '0;
      step();

      // Random traffic
      repeat (600) begin
         int r;
         cyc  = 3'($urandom) | (($urandom % 4 != 0) ? 3'b111 : 3'b000);
         stb  = 3'($urandom);
         we   = 3'($urandom);
         for (int k = 0; k < NUM; k++) begin
            addr_a[k] = 16'($urandom);
            wdat_a[k] = 8'($urandom);
         end
         slot  = ($urandom % 3 == 0);
         r     = int'($urandom % 4);
         grant = (r == 3) ? 3'b000 : (3'b001 << r);
         stall = ($urandom % 5 == 0);
         ack   = ($urandom % 4 == 0);
         rdat  = 8'($urandom);
         tclr  = ($urandom % 10 == 0);
         rst_n = ($urandom % 64 != 0);
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
